// File: rtl/step_input_conditioner.sv
// step_input_conditioner: synchronise and debounce a data switch and a step button into one-shot ena pulses
// Ports: clk/rst (sync, active-high); sw_data_raw, btn_step_raw async raw inputs;
//        sig_to_test captured bit, ena single-cycle strobe, hist newest-at-bit-0 history, step_count accepted steps.
module step_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20,
    parameter int HIST_LEN        = 8,
    parameter bit BTN_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_data_raw,
    input  logic                btn_step_raw,
    output logic                sig_to_test,
    output logic                ena,
    output logic [HIST_LEN-1:0] hist,
    output logic [7:0]          step_count
);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, PULSE, WAIT_RELEASE} state_t;
    logic [SYNC_STAGES-1:0] data_sync, btn_sync;
    logic [1:0]             lvl, db;
    logic [DB_W-1:0]        cnt [2];
    state_t                 state, state_n;
    // Button chain resets to the raw released level; polarity is normalised to pressed=1 after the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sync <= '0;
            btn_sync  <= {SYNC_STAGES{BTN_ACTIVE_LOW}};
        end else begin
            data_sync <= {data_sync[SYNC_STAGES-2:0], sw_data_raw};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_step_raw};
        end
    end
    assign lvl = {btn_sync[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW, data_sync[SYNC_STAGES-1]};
    // Index 0 = data, 1 = button; the level flips only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || lvl[k] == db[k]) begin
                cnt[k] <= '0;
                if (rst) db[k] <= 1'b0;
            end else if (cnt[k] == DB_LAST) begin
                cnt[k] <= '0;
                db[k]  <= ~db[k];
            end else begin
                cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        state <= rst ? WAIT_RELEASE : state_n;
    end
    always_comb begin
        state_n = WAIT_RELEASE;
        case (state)
            IDLE:         state_n = db[1] ? PULSE : IDLE;
            PULSE:        state_n = WAIT_RELEASE;
            WAIT_RELEASE: state_n = db[1] ? WAIT_RELEASE : IDLE;
            default:      state_n = WAIT_RELEASE;
        endcase
    end
    // ena is registered from the next state so it is high exactly while the FSM sits in PULSE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_to_test <= 1'b0;
            ena         <= 1'b0;
            hist        <= '0;
            step_count  <= '0;
        end else begin
            ena <= state_n == PULSE;
            if (state == IDLE && db[1]) sig_to_test <= db[0];
            if (state == PULSE) begin
                hist       <= {hist[HIST_LEN-2:0], sig_to_test};
                step_count <= step_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_step_input_conditioner.sv
// tb_step_input_conditioner: randomised and directed bench with a windowed behavioural model
module tb_step_input_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HL   = 8;
    logic          clk = 1'b0, rst = 1'b1, sw = 1'b0, btn = 1'b1;
    logic          sig_to_test, ena;
    logic [HL-1:0] hist;
    logic [7:0]    step_count;
    int            vectors = 0, errors = 0, pulses = 0;
    step_input_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .DB_W(3), .HIST_LEN(HL), .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .sw_data_raw(sw), .btn_step_raw(btn),
        .sig_to_test(sig_to_test), .ena(ena), .hist(hist), .step_count(step_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    // Model: raw samples delayed SYNC edges; a debounced level flips once the last DEB samples all differ from it.
    // A debounced press fires one pulse the next edge if a debounced release has been seen since the last pulse/reset.
    bit        qd[$], qb[$], wd[$], wb[$];
    bit        m_valid = 0, dbd, dbb, armed, m_ena, m_sig, sd, sb;
    logic [7:0] m_hist, m_cnt;
    function automatic bit all_differ(input bit w[$], input bit level);
        if (w.size() < DEB) return 1'b0;
        foreach (w[i]) if (w[i] == level) return 1'b0;
        return 1'b1;
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            qd = {}; qb = {}; wd = {}; wb = {};
            repeat (SYNC) begin qd.push_front(1'b0); qb.push_front(1'b0); end
            dbd = 0; dbb = 0; armed = 0; m_ena = 0; m_sig = 0; m_hist = '0; m_cnt = '0; m_valid = 1;
        end else if (m_valid) begin
            sd = qd[SYNC-1];
            sb = qb[SYNC-1];
            if (m_ena) begin
                m_hist = {m_hist[HL-2:0], m_sig};
                m_cnt  = m_cnt + 8'd1;
                m_ena  = 0;
            end else if (armed && dbb) begin
                m_ena = 1; m_sig = dbd; armed = 0;
            end
            if (!dbb) armed = 1;
            qd.push_front(sw);   void'(qd.pop_back());
            qb.push_front(~btn); void'(qb.pop_back());
            wd.push_front(sd); if (wd.size() > DEB) void'(wd.pop_back());
            wb.push_front(sb); if (wb.size() > DEB) void'(wb.pop_back());
            if (all_differ(wd, dbd)) dbd = ~dbd;
            if (all_differ(wb, dbb)) dbb = ~dbb;
        end
    end
    always @(negedge clk) begin
        if (m_valid) begin
            check("ena", ena, m_ena);
            check("sig_to_test", sig_to_test, m_sig);
            check("hist", hist, m_hist);
            check("step_count", step_count, m_cnt);
        end
        if (ena === 1'b1) pulses++;
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press(input bit d);
        sw = d; btn = 1'b0; tick(12);
        btn = 1'b1; tick(12);
    endtask
    // Press now and return the index of the first observed ena cycle (edge 1 samples the press) and its sig_to_test.
    task automatic timed_press(input bit d, output int lat, output logic s);
        lat = 0; s = 1'bx;
        sw = d; btn = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ena === 1'b1 && lat == 0) begin lat = k; s = sig_to_test; end
        end
    endtask
    int   lat, p0;
    logic s;
    bit   bits [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    initial begin
        tick(2);
        rst = 1'b0;
        check("rst_ena", ena, 1'b0);
        check("rst_sig", sig_to_test, 1'b0);
        check("rst_hist", hist, 8'h00);
        check("rst_count", step_count, 8'h00);
        tick(3);
        p0 = pulses;
        timed_press(1'b1, lat, s);
        check("latency", lat, 7);
        check("press_sig", s, 1'b1);
        check("one_pulse", pulses - p0, 1);
        check("hist_after_1", hist, 8'h01);
        check("count_after_1", step_count, 8'd1);
        btn = 1'b1; tick(12);
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin btn = (i % 2 == 0) ? 1'b0 : 1'b1; tick(2); end
        check("bounce_press_none", pulses - p0, 0);
        timed_press(1'b0, lat, s);
        check("bounce_latency", lat, 7);
        for (int i = 0; i < 10; i++) begin btn = (i % 2 == 0) ? 1'b1 : 1'b0; tick(2); end
        btn = 1'b1; tick(12);
        check("bounce_total", pulses - p0, 1);
        rst = 1'b1; tick(2); rst = 1'b0; tick(3);
        p0 = pulses;
        foreach (bits[i]) begin
            timed_press(bits[i], lat, s);
            check("seq_sig", s, bits[i]);
            btn = 1'b1; tick(12);
        end
        check("seq_pulses", pulses - p0, 5);
        check("seq_hist", hist, 8'h09);
        check("seq_count", step_count, 8'd5);
        btn = 1'b0; rst = 1'b1; tick(3); rst = 1'b0; tick(12);
        btn = 1'b1; tick(12);
        p0 = pulses;
        press(1'b1);
        check("after_held_rst", pulses - p0, 1);
        rst = 1'b1; tick(2); rst = 1'b0; tick(3);
        for (int i = 0; i < 256; i++) press(1'b1);
        check("wrap_count", step_count, 8'd0);
        check("wrap_hist", hist, 8'hFF);
        p0 = pulses;
        btn = 1'b0; tick(6);
        rst = 1'b1; btn = 1'b1; tick(2); rst = 1'b0;
        check("abort_ena", ena, 1'b0);
        tick(10);
        check("abort_pulses", pulses - p0, 0);
        check("abort_count", step_count, 8'd0);
        for (int i = 0; i < 1500; i++) begin
            sw  = 1'($urandom);
            btn = 1'($urandom);
            if ($urandom_range(0, 99) < 2) begin rst = 1'b1; tick($urandom_range(1, 2)); rst = 1'b0; end
            tick($urandom_range(1, 8));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
